// File: rtl/if_fetch_queue_if.sv
// Fetch-stage bundle: redirect input, instruction-memory request/response channel
// and the IF->ID valid/ready output. master = fetch queue, slave = its environment.
interface if_fetch_queue_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_addr;
  logic              i_req_valid;
  logic              i_req_ready;
  logic [ADDR_W-1:0] i_addr;
  logic              i_resp_valid;
  logic [DATA_W-1:0] i_resp_data;
  logic              if_id_valid;
  logic              if_id_ready;
  logic [DATA_W-1:0] IF_ID_instruction;
  logic [ADDR_W-1:0] IF_ID_next_i_addr;

  modport master (
    input  redirect_valid, redirect_addr, i_req_ready, i_resp_valid, i_resp_data, if_id_ready,
    output i_req_valid, i_addr, if_id_valid, IF_ID_instruction, IF_ID_next_i_addr
  );

  modport slave (
    output redirect_valid, redirect_addr, i_req_ready, i_resp_valid, i_resp_data, if_id_ready,
    input  i_req_valid, i_addr, if_id_valid, IF_ID_instruction, IF_ID_next_i_addr
  );
endinterface

// File: rtl/if_fetch_queue.sv
// Decoupled instruction fetch: credit-limited in-order requests, DEPTH-entry
// instruction queue towards ID, redirect flush with squashing of stale responses.
module if_fetch_queue #(
  parameter int              ADDR_W     = 32,
  parameter int              DATA_W     = 32,
  parameter int              DEPTH      = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int              ADDR_SHIFT = 2
) (
  input logic              clk,
  input logic              rst,
  if_fetch_queue_if.master bus
);
  localparam int                CNT_W   = $clog2(DEPTH + 1);
  localparam int                PTR_W   = $clog2(DEPTH);
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  logic [ADDR_W-1:0] pc_q, pc_d, resp_pc_q, resp_pc_d, redir_pc;
  logic [CNT_W-1:0]  inflight_q, inflight_d, discard_q, discard_d, count_q, count_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [ADDR_W-1:0] next_q [DEPTH];
  logic [CNT_W:0]    credit_used;
  logic              req_fire, resp_live, push, pop;

  assign redir_pc    = bus.redirect_addr & ~ADDR_W'(3);
  // Credits cover both outstanding requests and buffered entries, so a push can never overflow.
  assign credit_used = {1'b0, inflight_q} + {1'b0, count_q};

  assign bus.i_req_valid = !rst && !bus.redirect_valid && (credit_used < {1'b0, DEPTH_C});
  assign bus.i_addr      = pc_q >> ADDR_SHIFT;

  assign req_fire  = bus.i_req_valid && bus.i_req_ready;
  assign resp_live = bus.i_resp_valid && (inflight_q != '0);
  assign push      = resp_live && (discard_q == '0) && !bus.redirect_valid;
  assign pop       = (count_q != '0) && bus.if_id_ready && !bus.redirect_valid;

  always_comb begin
    pc_d       = pc_q;
    resp_pc_d  = resp_pc_q;
    discard_d  = discard_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    inflight_d = inflight_q + CNT_W'(req_fire) - CNT_W'(resp_live);
    if (bus.redirect_valid) begin
      pc_d      = redir_pc;
      resp_pc_d = redir_pc;
      count_d   = '0;
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
      // Everything still outstanding after this cycle belongs to the old path.
      discard_d = inflight_q - CNT_W'(resp_live);
    end else begin
      if (req_fire) pc_d = pc_q + PC_STEP;
      if (push) begin
        resp_pc_d = resp_pc_q + PC_STEP;
        wr_ptr_d  = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (resp_live && (discard_q != '0)) discard_d = discard_q - CNT_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      inflight_q <= '0;
      discard_q  <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      pc_q       <= pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (rst) begin
        data_q[i] <= '0;
        next_q[i] <= '0;
      end else if (push && (wr_ptr_q == PTR_W'(i))) begin
        data_q[i] <= bus.i_resp_data;
        next_q[i] <= resp_pc_q + PC_STEP;
      end
    end
  end

  assign bus.if_id_valid       = (count_q != '0);
  assign bus.IF_ID_instruction = data_q[rd_ptr_q];
  assign bus.IF_ID_next_i_addr = next_q[rd_ptr_q];

  a_count_bound: assert property (@(posedge clk) disable iff (rst) count_q <= DEPTH_C);
endmodule

// File: tb/tb_if_fetch_queue.sv
// Scoreboard bench for if_fetch_queue: in-order memory model with programmable
// latency, expected IF/ID entries queued by the stimulus and checked by a monitor.
module tb_if_fetch_queue;
  localparam int DEPTH = 4;

  typedef struct { logic [31:0] data; logic [31:0] nxt; } exp_t;
  typedef struct { logic [31:0] word; int due; } mreq_t;

  logic clk;
  logic rst;

  if_fetch_queue_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  if_fetch_queue #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .RESET_PC(32'h0), .ADDR_SHIFT(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  exp_t        sb[$];
  mreq_t       mem[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lat = 1;
  int          popped = 0;
  int          accepted = 0;
  int          max_out = 0;
  int          first_acc = -1;
  int          first_vld = -1;
  logic [31:0] exp_pc = 32'h0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Instruction image: word w holds 0xA5A5_wwww.
  task automatic push_exp(input logic [31:0] pc0, input int n);
    logic [31:0] pc;
    logic [31:0] w;
    exp_t        e;
    pc = pc0;
    for (int k = 0; k < n; k++) begin
      w      = pc >> 2;
      e.data = {16'hA5A5, w[15:0]};
      e.nxt  = pc + 32'd4;
      sb.push_back(e);
      pc = pc + 32'd4;
    end
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic step(input logic rdy, input logic redir, input logic [31:0] raddr,
                      input logic do_rst, input logic spur);
    int          out;
    mreq_t       m;
    logic [31:0] w;
    if (do_rst) begin
      mem.delete();
      sb.delete();
      exp_pc    = 32'h0;
      popped    = 0;
      accepted  = 0;
      max_out   = 0;
      first_acc = -1;
      first_vld = -1;
    end
    out = accepted - popped;
    if (out > max_out) max_out = out;
    rst                = do_rst;
    bus.redirect_valid = redir;
    bus.redirect_addr  = raddr;
    bus.if_id_ready    = rdy;
    bus.i_req_ready    = 1'b1;
    if (spur) begin
      bus.i_resp_valid = 1'b1;
      bus.i_resp_data  = 32'hDEAD_BEEF;
    end else if (!do_rst && mem.size() > 0 && mem[0].due <= cyc) begin
      w                = mem[0].word;
      bus.i_resp_valid = 1'b1;
      bus.i_resp_data  = {16'hA5A5, w[15:0]};
      void'(mem.pop_front());
    end else begin
      bus.i_resp_valid = 1'b0;
      bus.i_resp_data  = 32'h0;
    end
    if (redir) begin
      sb.delete();
      exp_pc = raddr & 32'hFFFF_FFFC;
    end
    #1;
    if (do_rst) chk32("no_req_in_reset", {31'b0, bus.i_req_valid}, 32'h0);
    if (redir)  chk32("no_req_on_redirect", {31'b0, bus.i_req_valid}, 32'h0);
    if (!do_rst && bus.if_id_valid === 1'b1 && first_vld < 0) first_vld = cyc;
    if (bus.i_req_valid === 1'b1 && bus.i_req_ready === 1'b1) begin
      chk32("req_word_addr", bus.i_addr, exp_pc >> 2);
      m.word = bus.i_addr;
      m.due  = cyc + lat;
      mem.push_back(m);
      if (first_acc < 0) first_acc = cyc;
      exp_pc = exp_pc + 32'd4;
      accepted++;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic run(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (popped < target && n < budget) begin
      step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      n++;
    end
    if (popped < target) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: popped %0d, required %0d", name, popped, target);
    end
  endtask

  // Monitor: every ID handshake pops the scoreboard and compares.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst !== 1'b1 && bus.redirect_valid !== 1'b1 &&
          bus.if_id_valid === 1'b1 && bus.if_id_ready === 1'b1) begin
        popped++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got instr 0x%08h next 0x%08h, expected none",
                   bus.IF_ID_instruction, bus.IF_ID_next_i_addr);
        end else begin
          e = sb.pop_front();
          chk32("if_id_instruction", bus.IF_ID_instruction, e.data);
          chk32("if_id_next_i_addr", bus.IF_ID_next_i_addr, e.nxt);
        end
      end
    end
  end

  initial begin : stimulus
    int t0;
    int p0;
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_addr  = 32'h0;
    bus.i_req_ready    = 1'b1;
    bus.i_resp_valid   = 1'b0;
    bus.i_resp_data    = 32'h0;
    bus.if_id_ready    = 1'b0;
    @(negedge clk);

    // Reset state, single-cycle memory, streaming
    lat = 1;
    do_reset();
    chk32("rst_i_req_valid", {31'b0, bus.i_req_valid}, 32'h0);
    chk32("rst_if_id_valid", {31'b0, bus.if_id_valid}, 32'h0);
    chk32("rst_instruction", bus.IF_ID_instruction, 32'h0);
    chk32("rst_next_i_addr", bus.IF_ID_next_i_addr, 32'h0);
    push_exp(32'h0, 8);
    run(8, 60, "stream_lat1");
    chk32("valid_after_first_accept", 32'(first_vld - first_acc), 32'd2);

    // Latency 2: one instruction per cycle once the pipe is full
    lat = 2;
    do_reset();
    push_exp(32'h0, 16);
    run(4, 60, "stream_lat2_warm");
    t0 = cyc;
    run(16, 60, "stream_lat2");
    chk32("lat2_cycles_for_12", 32'(cyc - t0), 32'd12);

    // Latency 3: credit cap holds and order is preserved
    lat = 3;
    do_reset();
    push_exp(32'h0, 12);
    run(12, 100, "stream_lat3");
    chk32("lat3_outstanding_le_depth", {31'b0, max_out <= DEPTH}, 32'h1);

    // ID stall for 10 cycles, then drain
    lat = 1;
    do_reset();
    repeat (10) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk32("stall_i_req_valid", {31'b0, bus.i_req_valid}, 32'h0);
    chk32("stall_if_id_valid", {31'b0, bus.if_id_valid}, 32'h1);
    chk32("stall_accepted", 32'(accepted), 32'd4);
    push_exp(32'h0, 8);
    run(8, 60, "stall_drain");
    chk32("stall_outstanding_le_depth", {31'b0, max_out <= DEPTH}, 32'h1);

    // Redirect to 0x103 with two requests in flight
    lat = 3;
    do_reset();
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk32("redir_accepted", 32'(accepted), 32'd2);
    step(1'b1, 1'b1, 32'h0000_0103, 1'b0, 1'b0);
    push_exp(32'h100, 6);
    run(6, 60, "redirect_0x103");

    // Redirect coinciding with a response and a pop
    lat = 2;
    do_reset();
    push_exp(32'h0, 20);
    repeat (10) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    chk32("pre_redirect_if_id_valid", {31'b0, bus.if_id_valid}, 32'h1);
    p0 = popped;
    step(1'b1, 1'b1, 32'h0000_0200, 1'b0, 1'b0);
    chk32("redirect_flush_empty", {31'b0, bus.if_id_valid}, 32'h0);
    push_exp(32'h200, 6);
    run(p0 + 6, 60, "redirect_0x200");

    // Reset with a full queue, then a spurious response
    lat = 1;
    do_reset();
    repeat (10) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk32("full_before_reset", {31'b0, bus.if_id_valid}, 32'h1);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk32("midrst_if_id_valid", {31'b0, bus.if_id_valid}, 32'h0);
    chk32("midrst_instruction", bus.IF_ID_instruction, 32'h0);
    push_exp(32'h0, 6);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    run(6, 60, "restart_after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Parametrised next-generation instruction-fetch stage for the pipelined MIPS core.
- Decouples PC generation from a variable-latency instruction memory:
  - issues in-order fetch requests over a valid/ready channel;
  - buffers returned instructions in a DEPTH-entry queue;
  - presents them to ID through a valid/ready handshake.
- Branch/jump redirects flush the queue and squash in-flight responses. The fixed single-cycle fetch and its IF/ID register are replaced.

Parameters:
- ADDR_W, 32, byte-address / PC width
- DATA_W, 32, instruction width
- DEPTH, 4, queue entries; also the cap on in-flight plus buffered fetches (power of 2, >=2)
- RESET_PC, 0, PC value loaded on reset
- ADDR_SHIFT, 2, right shift applied to PC to form the memory word address

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- redirect_valid  in  1  branch/jump taken this cycle
- redirect_addr  in  ADDR_W  new PC; bits [1:0] ignored (forced 0)
- i_req_valid  out  1  fetch request valid
- i_req_ready  in  1  memory accepts request
- i_addr  out  ADDR_W  word address = pc_reg >> ADDR_SHIFT
- i_resp_valid  in  1  instruction returned (in request order, any latency >=1)
- i_resp_data  in  DATA_W  returned instruction
- if_id_valid  out  1  queue head valid
- if_id_ready  in  1  ID consumes head (0 = hazard stall)
- IF_ID_instruction  out  DATA_W  head instruction
- IF_ID_next_i_addr  out  ADDR_W  head PC + 4

Behaviour:
- State:
  - pc_reg: next fetch PC.
  - resp_pc: PC of the next expected valid response.
  - inflight: accepted requests not yet responded, including stale ones.
  - discard: stale responses still to drop.
  - count: queue occupancy.
  - All counters are $clog2(DEPTH+1) bits.
- Reset (synchronous):
  - pc_reg = resp_pc = RESET_PC; inflight = discard = count = 0.
  - Outputs: i_req_valid=0, if_id_valid=0, IF_ID_instruction=0, IF_ID_next_i_addr=0.
  - Reset mid-operation abandons all outstanding requests. The memory is reset together with this block.
- Request:
  - i_req_valid = !rst && !redirect_valid && (inflight + count) < DEPTH.
  - On accept (valid && ready): pc_reg += 4 (wraps modulo 2^ADDR_W) and inflight += 1.
- Response:
  - Every i_resp_valid decrements inflight.
  - If inflight==0, the response is a protocol error: ignore it with no state change.
  - If discard>0, drop the response and decrement discard.
  - Otherwise push {i_resp_data, resp_pc+4} into the queue and set resp_pc += 4.
  - Overflow is impossible because of the credit rule; assert count<=DEPTH.
- Output:
  - if_id_valid = count>0.
  - IF_ID_* come from the queue head, registered storage with no combinational path from i_resp_*. Minimum latency from response to if_id_valid is 1 cycle.
  - Pop when if_id_valid && if_id_ready. Push and pop in the same cycle leave count unchanged.
  - When empty, outputs hold their last value and only if_id_valid=0 is meaningful.
- Redirect (highest priority, same cycle):
  - pc_reg = resp_pc = {redirect_addr[ADDR_W-1:2], 2'b00}.
  - count = 0; the queue is flushed and any pop or push this cycle is discarded.
  - discard = inflight - (i_resp_valid && inflight>0), so all pre-redirect requests are squashed. Any response arriving this cycle is dropped.
  - No request is issued in the redirect cycle. Fetch from the new PC starts on the next cycle.
  - Back-to-back redirects: the last one wins and discard is recomputed each time.
- Stall: with if_id_ready=0, the queue fills to DEPTH and then requests stop. No instruction is lost or duplicated.
- Throughput: 1 instruction/cycle sustained when memory latency <= DEPTH-1 cycles and there are no stalls.

Test Plan:
- Reset, single-cycle memory, if_id_ready=1:
  - requests to word addrs 0,1,2,3…;
  - IF_ID_next_i_addr sequence 4,8,12…;
  - if_id_valid rises 2 cycles after the first accept.
- 3-cycle memory latency, DEPTH=4: steady 1 instr/cycle; inflight+count never exceeds 4.
- if_id_ready=0 for 10 cycles:
  - count saturates at 4;
  - i_req_valid=0 once inflight+count=4;
  - on release, instrs 0x..00–0x..0C drain in order with no duplicates.
- Redirect to 0x0000_0103 with 2 requests in flight:
  - the 2 stale responses are dropped;
  - the next if_id_valid shows IF_ID_next_i_addr=0x104 and the instruction fetched from word 0x40.
- Redirect coinciding with a response and a pop:
  - queue empties;
  - that response is dropped;
  - discard = inflight-1;
  - no request that cycle.
- Assert rst mid-stream with a full queue:
  - next cycle if_id_valid=0 and i_req_valid=0;
  - after rst deasserts, fetch restarts at RESET_PC;
  - a spurious response with inflight=0 is ignored.
